dec_sel_sequencer: RTL

DEC_SEL_SEQUENCER -- requirements
Module: dec_sel_sequencer

---
 rtl/dec_sel_sequencer_if.sv | 29 ++
 rtl/dec_sel_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/dec_sel_sequencer_if.sv
// Control and select bundle between a sweep controller and the 2-to-4 decoder sequencer.
// Latency: n/a (signal grouping only).
// Backpressure: none; start/stop are level requests, outputs are registered status.
interface dec_sel_sequencer_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               mode;
  logic               dir;
  logic [DWELL_W-1:0] dwell;
  logic               s0;
  logic               s1;
  logic               blank;
  logic               busy;
  logic               done;

  // Controller side: issues requests and sweep settings, observes select/status.
  modport master (
    output start, stop, mode, dir, dwell,
    input  s0, s1, blank, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start, stop, mode, dir, dwell,
    output s0, s1, blank, busy, done
  );
endinterface

// File: rtl/dec_sel_sequencer.sv
// Steps a 2-bit decoder select through 00..11 (or 11..00), blanking GUARD cycles after each change.
// Latency: start sampled in IDLE loads the first code and blank on the same edge; all outputs are flops.
// Backpressure: none; start is ignored while busy, stop aborts to IDLE on the next edge.
module dec_sel_sequencer #(
  parameter int GUARD   = 2,
  parameter int DWELL_W = 8
) (
  input logic               clk,
  input logic               rst,
  dec_sel_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GUARD,
    ST_DWELL
  } state_t;

  // Counters run down to zero, so they are loaded with (length - 1).
  localparam logic [3:0]         GUARD_LAST = 4'(GUARD - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

  state_t             state_q, state_d;
  logic [1:0]         code_q, code_d;
  logic               blank_q, blank_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [3:0]         guard_cnt_q, guard_cnt_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic               mode_q, mode_d;
  logic               dir_q, dir_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  // Last code of a sweep: 11 going up, 00 going down.
  logic               last_code;
  assign last_code = dir_q ? (code_q == 2'b00) : (code_q == 2'b11);

  // State, counter, capture and output registers; reset wins over everything, including a pending done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      code_q      <= 2'b00;
      blank_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      guard_cnt_q <= '0;
      dwell_cnt_q <= '0;
      mode_q      <= 1'b0;
      dir_q       <= 1'b0;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      blank_q     <= blank_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      guard_cnt_q <= guard_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      mode_q      <= mode_d;
      dir_q       <= dir_d;
      dwell_q     <= dwell_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one edge ahead so they leave straight from flops.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    blank_d     = blank_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    guard_cnt_d = guard_cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    mode_d      = mode_q;
    dir_d       = dir_q;
    dwell_d     = dwell_q;

    case (state_q)
      ST_IDLE: begin
        blank_d = 1'b1;
        busy_d  = 1'b0;
        // stop has priority over start.
        if (bus.start && !bus.stop) begin
          mode_d      = bus.mode;
          dir_d       = bus.dir;
          // A zero dwell would otherwise wrap the down-counter; run it as one cycle.
          dwell_d     = (bus.dwell == '0) ? DWELL_ONE : bus.dwell;
          code_d      = bus.dir ? 2'b11 : 2'b00;
          blank_d     = 1'b1;
          busy_d      = 1'b1;
          guard_cnt_d = GUARD_LAST;
          state_d     = ST_GUARD;
        end
      end

      ST_GUARD: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          blank_d = 1'b1;
          busy_d  = 1'b0;
        end else if (guard_cnt_q == 4'd0) begin
          state_d     = ST_DWELL;
          blank_d     = 1'b0;
          dwell_cnt_d = dwell_q - DWELL_ONE;
        end else begin
          guard_cnt_d = guard_cnt_q - 4'd1;
        end
      end

      ST_DWELL: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          blank_d = 1'b1;
          busy_d  = 1'b0;
        end else if (dwell_cnt_q == '0) begin
          if (mode_q && last_code) begin
            // Single sweep complete: code holds its final value.
            state_d = ST_IDLE;
            blank_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // The code only ever changes here, on entry to GUARD; 2-bit arithmetic gives the wrap.
            code_d      = dir_q ? (code_q - 2'b01) : (code_q + 2'b01);
            state_d     = ST_GUARD;
            blank_d     = 1'b1;
            guard_cnt_d = GUARD_LAST;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q - DWELL_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        blank_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.s0    = code_q[0];
  assign bus.s1    = code_q[1];
  assign bus.blank = blank_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
